// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input
//
// Samples pwm_in through a 2-flop synchroniser, optionally inverts it, and on
// every rising edge of the active level reports the previous complete period.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset (release already synchronised)
//   pwm_in      asynchronous PWM input
//   high_cnt    active-level cycles of the last complete period
//   period_cnt  rise-to-rise cycles of the last complete period
//   meas_valid  one-cycle pulse when high_cnt/period_cnt update
//   locked      high while periodic edges are being received
//   timeout     one-cycle pulse when no rise was seen for TIMEOUT cycles
//   stuck_level active level sampled at the last timeout
//   duty8       floor(high_cnt*255/period_cnt)   (PWM_CAPTURE_DUTY_EN only)
//   duty_valid  one-cycle pulse when duty8 updates (PWM_CAPTURE_DUTY_EN only)
//
// Optional feature macro: PWM_CAPTURE_DUTY_EN adds the serial duty divider.
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 2400,
   parameter int INVERT  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout,
   output logic             stuck_level
`ifdef PWM_CAPTURE_DUTY_EN
   ,
   output logic [7:0]       duty8,
   output logic             duty_valid
`endif
);
   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic             INV = (INVERT != 0);

   state_t           state, state_nxt;
   logic             s1, s2, lvl, lvl_d, to_done, rise, tmo;
   logic [CNT_W-1:0] p_run, h_run;

   assign rise = lvl & ~lvl_d;
   // to_done limits a stuck input to a single timeout pulse until the next rise
   assign tmo  = (p_run == TMO) & ~to_done & ~rise;

   always_comb begin
      state_nxt = state;
      state_nxt = rise ? MEASURE : tmo ? IDLE : state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         // lvl/lvl_d start at the inactive level so release cannot fake a rise
         lvl         <= INV;
         lvl_d       <= INV;
         p_run       <= '0;
         h_run       <= '0;
         to_done     <= 1'b0;
         state       <= IDLE;
         high_cnt    <= '0;
         period_cnt  <= '0;
         meas_valid  <= 1'b0;
         locked      <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         s1         <= pwm_in;
         s2         <= s1;
         lvl        <= s2 ^ INV;
         lvl_d      <= lvl;
         p_run      <= rise ? CNT_W'(1) : (p_run == TMO) ? p_run : p_run + CNT_W'(1);
         h_run      <= rise ? CNT_W'(1) : (lvl && p_run != TMO) ? h_run + CNT_W'(1) : h_run;
         to_done    <= rise ? 1'b0 : tmo ? 1'b1 : to_done;
         state      <= state_nxt;
         meas_valid <= rise && state == MEASURE;
         timeout    <= tmo;
         if (rise && state == MEASURE) begin
            period_cnt <= p_run;
            high_cnt   <= h_run;
            locked     <= 1'b1;
         end else if (tmo) begin
            period_cnt  <= '0;
            high_cnt    <= '0;
            locked      <= 1'b0;
            stuck_level <= lvl;
         end
      end
   end

`ifdef PWM_CAPTURE_DUTY_EN
   localparam int N  = CNT_W + 8;
   localparam int IW = $clog2(N + 1);

   logic [N-1:0]   num;
   logic [CNT_W:0] rem, r2;
   logic [IW-1:0]  it;
   logic           busy, ge;

   // restoring division of high_cnt*255 by period_cnt; num shifts out the
   // dividend and shifts in quotient bits
   assign r2 = {rem[CNT_W-1:0], num[N-1]};
   assign ge = r2 >= {1'b0, period_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num        <= '0;
         rem        <= '0;
         it         <= '0;
         busy       <= 1'b0;
         duty8      <= '0;
         duty_valid <= 1'b0;
      end else begin
         duty_valid <= 1'b0;
         if (meas_valid) begin
            num  <= {high_cnt, 8'd0} - {8'd0, high_cnt};
            rem  <= '0;
            it   <= IW'(N);
            busy <= 1'b1;
         end else if (timeout) begin
            busy       <= 1'b0;
            duty8      <= {8{stuck_level}};
            duty_valid <= 1'b1;
         end else if (busy) begin
            rem <= ge ? r2 - {1'b0, period_cnt} : r2;
            num <= {num[N-2:0], ge};
            it  <= it - IW'(1);
            if (it == IW'(1)) begin
               busy       <= 1'b0;
               duty8      <= {num[6:0], ge};
               duty_valid <= 1'b1;
            end
         end
      end
   end
`endif
endmodule
